// File: rtl/adc_clk_sup_pkg.sv
// Shared types and constants for the ADC data-clock PLL supervisor.
package adc_clk_sup_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_PULSE = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        READY     = 3'd4,
        FAIL      = 3'd5
    } chan_state_t;

    localparam logic [7:0] LOSS_SAT = 8'hFF;

endpackage

// File: rtl/adc_pll_chan_fsm.sv
// One ADC PLL channel: lock synchronizer, reset/lock/stable sequencer, retry and loss counters.
// Lock reaches outputs 3 cycles after the raw input; no backpressure, all outputs registered.
module adc_pll_chan_fsm
    import adc_clk_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 100,
    parameter int LOCK_TIMEOUT  = 1_000_000,
    parameter int STABLE_CYCLES = 1000,
    parameter int MAX_RETRY     = 8,
    parameter int CNT_W         = 24
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       en,
    input  logic       locked,
    input  logic       retry_clr,
    output logic       pll_rst,
    output logic       clk_ok,
    output logic       fail,
    output logic [7:0] loss_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRY);

    chan_state_t      state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [7:0]       retry, retry_nxt, retry_inc;
    logic [7:0]       loss_nxt;
    logic             lock_meta, lock_s;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        retry_nxt = retry;
        loss_nxt  = loss_cnt;
        retry_inc = retry + 8'd1;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RST_PULSE;
                    timer_nxt = '0;
                end
            end
            RST_PULSE: begin
                if (timer == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // lock on the timeout cycle still wins
                if (lock_s) begin
                    state_nxt = STABLE;
                    timer_nxt = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_MAX) ? FAIL : RST_PULSE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_MAX) ? FAIL : RST_PULSE;
                    timer_nxt = '0;
                end else if (timer == STABLE_LAST) begin
                    state_nxt = READY;
                    retry_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            READY: begin
                if (!lock_s) begin
                    loss_nxt  = (loss_cnt == LOSS_SAT) ? loss_cnt : loss_cnt + 8'd1;
                    state_nxt = RST_PULSE;
                    timer_nxt = '0;
                end
            end
            FAIL: begin
                if (retry_clr) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
        // Disable discards any retry or loss bookkeeping from this cycle.
        if (!en) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            retry_nxt = retry;
            loss_nxt  = loss_cnt;
        end
        if (retry_clr) begin
            retry_nxt = '0;
            loss_nxt  = '0;
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            state     <= IDLE;
            timer     <= '0;
            retry     <= '0;
            loss_cnt  <= '0;
            pll_rst   <= 1'b1;
            clk_ok    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_s    <= lock_meta;
            state     <= state_nxt;
            timer     <= timer_nxt;
            retry     <= retry_nxt;
            loss_cnt  <= loss_nxt;
            pll_rst   <= (state_nxt == IDLE) || (state_nxt == RST_PULSE) || (state_nxt == FAIL);
            clk_ok    <= (state_nxt == READY);
            fail      <= (state_nxt == FAIL);
        end
    end

endmodule

// File: rtl/adc_clk_supervisor.sv
// Two-channel ADC DCLK PLL supervisor: per-channel reset sequencing, lock qualification, re-arm.
// Raw lock to adc_clk_ok is 3 cycles; no backpressure, consumers resynchronize adc_clk_ok.
module adc_clk_supervisor
    import adc_clk_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 100,
    parameter int LOCK_TIMEOUT  = 1_000_000,
    parameter int STABLE_CYCLES = 1000,
    parameter int MAX_RETRY     = 8,
    parameter int CNT_W         = 24
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic [1:0]  adc_en,
    input  logic [1:0]  adc_locked,
    input  logic        retry_clr,
    output logic [1:0]  adc_pll_rst,
    output logic [1:0]  adc_clk_ok,
    output logic [1:0]  adc_fail,
    output logic [15:0] lock_loss_cnt
);

    for (genvar i = 0; i < 2; i++) begin : g_chan
        adc_pll_chan_fsm #(
            .RST_CYCLES   (RST_CYCLES),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .STABLE_CYCLES(STABLE_CYCLES),
            .MAX_RETRY    (MAX_RETRY),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk_100mhz(clk_100mhz),
            .reset     (reset),
            .en        (adc_en[i]),
            .locked    (adc_locked[i]),
            .retry_clr (retry_clr),
            .pll_rst   (adc_pll_rst[i]),
            .clk_ok    (adc_clk_ok[i]),
            .fail      (adc_fail[i]),
            .loss_cnt  (lock_loss_cnt[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_adc_clk_supervisor.sv
// Directed bench for adc_clk_supervisor with short timing parameters.
module tb_adc_clk_supervisor;

    logic        clk_100mhz = 1'b0;
    logic        reset;
    logic [1:0]  adc_en;
    logic [1:0]  adc_locked;
    logic        retry_clr;
    logic [1:0]  adc_pll_rst;
    logic [1:0]  adc_clk_ok;
    logic [1:0]  adc_fail;
    logic [15:0] lock_loss_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    adc_clk_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (3),
        .CNT_W        (24)
    ) dut (
        .clk_100mhz   (clk_100mhz),
        .reset        (reset),
        .adc_en       (adc_en),
        .adc_locked   (adc_locked),
        .retry_clr    (retry_clr),
        .adc_pll_rst  (adc_pll_rst),
        .adc_clk_ok   (adc_clk_ok),
        .adc_fail     (adc_fail),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100mhz);
            #1;
        end
    endtask

    // sel: 0 = adc_clk_ok, 1 = adc_pll_rst, 2 = adc_fail
    function automatic logic sig(input int sel, input int ch);
        case (sel)
            0:       return adc_clk_ok[ch];
            1:       return adc_pll_rst[ch];
            default: return adc_fail[ch];
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel, input int ch, input logic val,
                            input int budget);
        int n = 0;
        while (sig(sel, ch) !== val && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(sig(sel, ch)), 32'(val));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        adc_en     = 2'b00;
        adc_locked = 2'b00;
        retry_clr  = 1'b0;
        tick(2);
        chk("reset_pll_rst", 32'(adc_pll_rst), 32'h3);
        chk("reset_ok", 32'(adc_clk_ok), 32'h0);
        chk("reset_fail", 32'(adc_fail), 32'h0);
        chk("reset_loss", 32'(lock_loss_cnt), 32'h0);

        // Clean bring-up on channel 0
        reset  = 1'b0;
        adc_en = 2'b01;
        tick(4);
        chk("bring_rst0_high", 32'(adc_pll_rst[0]), 1);
        tick(1);
        chk("bring_rst0_low", 32'(adc_pll_rst[0]), 0);
        chk("bring_rst1_high", 32'(adc_pll_rst[1]), 1);
        tick(10);
        adc_locked[0] = 1'b1;
        tick(10);
        chk("bring_ok_early", 32'(adc_clk_ok[0]), 0);
        tick(1);
        chk("bring_ok", 32'(adc_clk_ok), 32'h1);
        chk("bring_rst", 32'(adc_pll_rst), 32'h2);

        // Loss in READY: ok falls 3 cycles after the raw edge
        adc_locked[0] = 1'b0;
        tick(2);
        chk("loss_ok_hold", 32'(adc_clk_ok[0]), 1);
        tick(1);
        chk("loss_ok_fall", 32'(adc_clk_ok[0]), 0);
        chk("loss_rst_rise", 32'(adc_pll_rst[0]), 1);
        chk("loss_cnt_1", 32'(lock_loss_cnt), 32'h1);

        cnt = 1;
        for (int i = 0; i < 299; i++) begin
            adc_locked[0] = 1'b1;
            wait_sig("sat_relock", 0, 0, 1'b1, 100);
            adc_locked[0] = 1'b0;
            wait_sig("sat_drop", 0, 0, 1'b0, 10);
            cnt++;
            if (cnt >= 254 && cnt <= 256)
                chk("sat_cnt", 32'(lock_loss_cnt[7:0]), (cnt > 255) ? 255 : cnt);
            if (n_err != 0) break;
        end
        chk("sat_final", 32'(lock_loss_cnt), 32'h00FF);

        // retry_clr on the same edge as a loss increment
        adc_locked[0] = 1'b1;
        wait_sig("clr_relock", 0, 0, 1'b1, 100);
        adc_locked[0] = 1'b0;
        tick(2);
        retry_clr = 1'b1;
        tick(1);
        retry_clr = 1'b0;
        chk("clr_beats_loss", 32'(lock_loss_cnt), 32'h0);
        chk("clr_ok_low", 32'(adc_clk_ok[0]), 0);

        // Glitch during STABLE
        wait_sig("gl_wait_lock", 1, 0, 1'b0, 20);
        adc_locked[0] = 1'b1;
        tick(5);
        adc_locked[0] = 1'b0;
        tick(1);
        adc_locked[0] = 1'b1;
        tick(1);
        chk("gl_rst_low", 32'(adc_pll_rst[0]), 0);
        tick(1);
        chk("gl_rst_high", 32'(adc_pll_rst[0]), 1);
        chk("gl_ok_low", 32'(adc_clk_ok[0]), 0);
        wait_sig("gl_ready", 0, 0, 1'b1, 100);

        // READY cleared retry: a full three timeouts are needed to reach FAIL
        adc_locked[0] = 1'b0;
        tick(74);
        chk("rc_fail_early", 32'(adc_fail[0]), 0);
        tick(1);
        chk("rc_fail", 32'(adc_fail[0]), 1);
        chk("rc_rst", 32'(adc_pll_rst[0]), 1);
        chk("rc_loss", 32'(lock_loss_cnt), 32'h1);

        // Timeout to FAIL on channel 1
        adc_en = 2'b10;
        tick(72);
        chk("to_fail_early", 32'(adc_fail[1]), 0);
        tick(1);
        chk("to_fail", 32'(adc_fail), 32'h2);
        chk("to_rst", 32'(adc_pll_rst[1]), 1);
        retry_clr = 1'b1;
        tick(1);
        retry_clr = 1'b0;
        chk("to_clr_fail", 32'(adc_fail[1]), 0);
        chk("to_clr_rst", 32'(adc_pll_rst[1]), 1);
        tick(4);
        chk("to_retry_rst_high", 32'(adc_pll_rst[1]), 1);
        tick(1);
        chk("to_retry_rst_low", 32'(adc_pll_rst[1]), 0);

        // Disable on the cycle of the second timeout: retry stays at 1
        tick(43);
        adc_en = 2'b00;
        tick(1);
        chk("pri_idle_rst", 32'(adc_pll_rst[1]), 1);
        chk("pri_idle_fail", 32'(adc_fail[1]), 0);
        adc_en = 2'b10;
        tick(25);
        chk("pri_no_fail_1st", 32'(adc_fail[1]), 0);
        tick(23);
        chk("pri_no_fail_2nd", 32'(adc_fail[1]), 0);
        tick(1);
        chk("pri_fail", 32'(adc_fail[1]), 1);

        // Async reset while both channels are READY
        retry_clr  = 1'b1;
        adc_en     = 2'b11;
        adc_locked = 2'b11;
        tick(1);
        retry_clr = 1'b0;
        wait_sig("ar_ok0", 0, 0, 1'b1, 100);
        wait_sig("ar_ok1", 0, 1, 1'b1, 100);
        @(posedge clk_100mhz);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_rst_now", 32'(adc_pll_rst), 32'h3);
        chk("ar_ok_now", 32'(adc_clk_ok), 32'h0);
        adc_locked = 2'b01;
        tick(2);
        reset = 1'b0;
        tick(4);
        chk("ar_seq_rst_high", 32'(adc_pll_rst), 32'h3);
        tick(1);
        chk("ar_seq_rst_low", 32'(adc_pll_rst), 32'h0);
        tick(9);
        chk("ar_ch0_ready", 32'(adc_clk_ok), 32'h1);
        adc_locked = 2'b11;
        tick(10);
        chk("ar_ch1_not_yet", 32'(adc_clk_ok), 32'h1);
        tick(1);
        chk("ar_both_ready", 32'(adc_clk_ok), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
